// File: rtl/bmem_dumper_pkg.sv
// Shared constants for the serial loader / block-memory dumper pair.
//   - loader opcodes (top two bits of every frame header byte)
//   - BMEM_TAG: header byte of a block-memory frame
//   - dumper FSM state encoding
//   - frame_len(): bytes in one BMEM frame (tag + address + block)
package bmem_dumper_pkg;

  typedef enum logic [1:0] {
    OP_INVALID = 2'b00,
    OP_IMEM    = 2'b01,
    OP_BMEM    = 2'b10,
    OP_UPDATE  = 2'b11
  } loader_op_e;

  localparam logic [7:0] BMEM_TAG = {OP_BMEM, 6'b00_0000};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_LOCK,
    ST_SEND,
    ST_DONE
  } state_e;

  function automatic int frame_len(input int bitwidth, input int words);
    return 1 + bitwidth / 8 + (bitwidth / 8) * words;
  endfunction

endpackage

// File: rtl/bmem_dumper_if.sv
// Command, block-memory read and UART write-lock signals of the dumper.
//   master : the dumper (drives busy/done, read address, lock request, bytes)
//   slave  : host side / memory / UART controller
//   start, start_addr        dump request and block address
//   busy, done               progress
//   bmem_read_addr/data      block memory read, data one cycle after address
//   write_lock_req/res       UART write lock handshake
//   write_ready, write_data, write_data_valid   byte stream to UART
interface bmem_dumper_if #(
  parameter int BITWIDTH = 32,
  parameter int WORDS    = 16
);
  logic                start;
  logic [BITWIDTH-1:0] start_addr;
  logic                busy;
  logic                done;
  logic [BITWIDTH-1:0] bmem_read_addr;
  logic [BITWIDTH-1:0] bmem_read_data [WORDS];
  logic                write_lock_req;
  logic                write_lock_res;
  logic                write_ready;
  logic [7:0]          write_data;
  logic                write_data_valid;

  modport master (
    input  start, start_addr, bmem_read_data, write_lock_res, write_ready,
    output busy, done, bmem_read_addr, write_lock_req, write_data, write_data_valid
  );

  modport slave (
    output start, start_addr, bmem_read_data, write_lock_res, write_ready,
    input  busy, done, bmem_read_addr, write_lock_req, write_data, write_data_valid
  );
endinterface

// File: rtl/bmem_dumper_frame_serializer.sv
// Streams a flattened frame vector out one byte at a time, byte 0 in bits [7:0].
//   clock, reset   clock / async active-low reset
//   load_i         restart at byte 0 (preloads the output register)
//   active_i       offer bytes this cycle
//   frame_i        frame contents, must stay stable while active
//   ready_i        sink accepts a byte this cycle
//   lock_i         write lock currently granted
//   data_o         current byte (registered)
//   valid_o        data_o offered
//   last_o         final byte accepted this cycle
module bmem_dumper_frame_serializer #(
  parameter  int NBYTES = 69,
  localparam int CW     = $clog2(NBYTES + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_i,
  input  logic                active_i,
  input  logic [8*NBYTES-1:0] frame_i,
  input  logic                ready_i,
  input  logic                lock_i,
  output logic [7:0]          data_o,
  output logic                valid_o,
  output logic                last_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          accept, at_last;

  assign valid_o = active_i & lock_i;
  assign accept  = valid_o & ready_i;
  assign at_last = (cnt_q == CW'(NBYTES - 1));
  assign last_o  = accept & at_last;
  assign data_o  = data_q;

  // The next byte is selected from cnt_d so the output register already holds
  // it on the cycle after an accept; data_q only changes on load or accept.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (load_i) begin
      cnt_d  = '0;
      data_d = frame_i[7:0];
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
      if (!at_last) data_d = frame_i[int'(cnt_d)*8 +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/bmem_dumper.sv
// Block-memory dumper: on start, snapshots one tile block and sends it to the
// host as a BMEM frame (tag, address LSB first, words LSB byte first) through
// the shared UART write port, holding the write lock for the whole frame.
//   clock, reset   clock / async active-low reset
//   bus            bmem_dumper_if.master (command, memory read, UART write)
module bmem_dumper
  import bmem_dumper_pkg::*;
#(
  parameter int         BITWIDTH  = 32,
  parameter int         MESHUNITS = 2,
  parameter int         TILEUNITS = 2,
  parameter logic [7:0] TAG       = BMEM_TAG
) (
  input  logic           clock,
  input  logic           reset,
  bmem_dumper_if.master  bus
);
  localparam int WORDS = MESHUNITS * MESHUNITS * TILEUNITS * TILEUNITS;
  localparam int L     = frame_len(BITWIDTH, WORDS);

  state_e              st_q, st_d;
  logic [BITWIDTH-1:0] addr_q, addr_d;
  logic [BITWIDTH-1:0] cap_q [WORDS];
  logic [8*L-1:0]      frame;
  logic                load, active, last;
  logic                busy, done, lock_req;
  logic [BITWIDTH-1:0] rd_addr;

  always_comb begin
    st_d     = st_q;
    addr_d   = addr_q;
    load     = 1'b0;
    active   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    lock_req = 1'b0;
    rd_addr  = '0;
    case (st_q)
      ST_IDLE: if (bus.start) begin
        addr_d = bus.start_addr;
        st_d   = ST_READ;
      end
      ST_READ: begin
        busy    = 1'b1;
        rd_addr = addr_q;
        st_d    = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        busy    = 1'b1;
        rd_addr = addr_q;
        st_d    = ST_LOCK;
      end
      ST_LOCK: begin
        busy     = 1'b1;
        lock_req = 1'b1;
        if (bus.write_lock_res) begin
          load = 1'b1;
          st_d = ST_SEND;
        end
      end
      ST_SEND: begin
        busy     = 1'b1;
        lock_req = 1'b1;
        active   = 1'b1;
        if (last) st_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q   <= ST_IDLE;
      addr_q <= '0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
    end
  end

  // Snapshot: read data is valid during CAPTURE; later memory writes never
  // reach the frame because the serializer only sees cap_q.
  always_ff @(posedge clock) begin
    if (st_q == ST_CAPTURE)
      for (int w = 0; w < WORDS; w++) cap_q[w] <= bus.bmem_read_data[w];
  end

  always_comb begin
    frame        = '0;
    frame[7:0]   = TAG;
    frame[8 +: BITWIDTH] = addr_q;
    for (int w = 0; w < WORDS; w++)
      frame[8 + BITWIDTH + w*BITWIDTH +: BITWIDTH] = cap_q[w];
  end

  bmem_dumper_frame_serializer #(.NBYTES(L)) u_ser (
    .clock    (clock),
    .reset    (reset),
    .load_i   (load),
    .active_i (active),
    .frame_i  (frame),
    .ready_i  (bus.write_ready),
    .lock_i   (bus.write_lock_res),
    .data_o   (bus.write_data),
    .valid_o  (bus.write_data_valid),
    .last_o   (last)
  );

  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.write_lock_req = lock_req;
  assign bus.bmem_read_addr = rd_addr;
endmodule

// File: tb/tb_bmem_dumper.sv
module tb_bmem_dumper;
  localparam int BW = 32, WORDS = 16, L = 69;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bmem_dumper_if #(.BITWIDTH(BW), .WORDS(WORDS)) bus();
  bmem_dumper #(.BITWIDTH(BW), .MESHUNITS(2), .TILEUNITS(2)) u_dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  // block memory model: two blocks, registered read
  logic [31:0] m10 [WORDS];
  logic [31:0] m20 [WORDS];
  always @(posedge clock)
    for (int w = 0; w < WORDS; w++)
      bus.bmem_read_data[w] <= (bus.bmem_read_addr == 32'h10) ? m10[w] :
                               (bus.bmem_read_addr == 32'h20) ? m20[w] : 32'h0;

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected frame for a block holding words 1..16
  function automatic logic [7:0] exp_byte(input int k, input logic [31:0] addr);
    logic [31:0] word;
    if (k == 0) return 8'h80;
    if (k < 5) return addr[8*(k-1) +: 8];
    word = 32'((k - 5) / 4 + 1);
    return word[8*((k-5)%4) +: 8];
  endfunction

  logic [7:0] got [L+8];
  int n, done_cnt, first_valid, stab_err, revoke_low, wait_bad, timed_out;
  logic [31:0] rd0, rd1;
  logic busy_at_done;

  task automatic do_start(input logic [31:0] addr);
    @(negedge clock);
    bus.start = 1'b1;
    bus.start_addr = addr;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // mode 0 plain, 1 backpressure, 2 lock revoke, 3 start-while-busy/snapshot,
  // 4 reset at byte 40, 5 lock delay
  task automatic run_frame(input int mode);
    int reqc, rev;
    bit pend, sflag, mutated;
    logic [7:0] hold;
    reqc = 0; rev = 0; pend = 0; sflag = 0; mutated = 0; hold = 8'h0;
    n = 0; done_cnt = 0; first_valid = -1; stab_err = 0; revoke_low = 0;
    wait_bad = 0; timed_out = 1; rd0 = 'x; rd1 = 'x; busy_at_done = 1'bx;
    for (int it = 0; it < 600; it++) begin
      @(negedge clock);
      bus.start = 1'b0;
      bus.write_ready = (mode == 1) ? ((it % 4 == 0) || (it % 4 == 3)) : 1'b1;
      if (mode == 5) bus.write_lock_res = (reqc >= 20);
      else if (mode == 2 && n == 31 && rev < 5) begin
        bus.write_lock_res = 1'b0; rev++;
      end else bus.write_lock_res = 1'b1;
      if (mode == 3 && n == 10 && !sflag) begin
        bus.start = 1'b1; bus.start_addr = 32'h20; sflag = 1;
      end
      if (mode == 4 && n == 40) begin
        reset = 1'b0;
        #1;
        check("rst_mid_valid", bus.write_data_valid, 0);
        check("rst_mid_req",   bus.write_lock_req, 0);
        check("rst_mid_busy",  bus.busy, 0);
        check("rst_mid_done",  bus.done, 0);
        check("rst_mid_data",  bus.write_data, 0);
        check("rst_mid_raddr", bus.bmem_read_addr, 0);
        @(negedge clock);
        reset = 1'b1;
        timed_out = 0;
        return;
      end
      #1;
      if (it == 0) rd0 = bus.bmem_read_addr;
      if (it == 1) rd1 = bus.bmem_read_addr;
      if (mode == 5 && reqc > 0 && !bus.write_lock_res && (!bus.write_lock_req || bus.write_data_valid))
        wait_bad++;
      if (bus.write_lock_req) reqc++;
      if (mode == 3 && bus.write_lock_req && !mutated) begin
        for (int w = 0; w < WORDS; w++) m10[w] = 32'hDEAD0000 | w;
        mutated = 1;
      end
      if (bus.write_data_valid && !bus.write_lock_res) stab_err++;
      if (mode == 2 && !bus.write_lock_res && bus.write_lock_req && !bus.write_data_valid) revoke_low++;
      if (bus.write_data_valid && first_valid < 0) first_valid = it;
      if (bus.write_data_valid && pend && bus.write_data !== hold) stab_err++;
      if (bus.done) begin done_cnt++; busy_at_done = bus.busy; end
      if (bus.write_data_valid && bus.write_ready && bus.write_lock_res) begin
        if (n < L + 8) got[n] = bus.write_data;
        n++; pend = 0;
      end else if (bus.write_data_valid) begin
        pend = 1; hold = bus.write_data;
      end
      if (bus.done) begin timed_out = 0; break; end
    end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] addr);
    int mism;
    mism = 0;
    check({tag, "_len"}, n, L);
    for (int k = 0; k < L; k++) if (got[k] !== exp_byte(k, addr)) mism++;
    check({tag, "_bytes"}, mism, 0);
  endtask

  task automatic idle_check(input string tag);
    int act;
    act = 0;
    repeat (4) begin
      @(negedge clock); #1;
      if (bus.done || bus.busy || bus.write_lock_req || bus.write_data_valid) act++;
    end
    check(tag, act, 0);
  endtask

  task automatic restore_mem();
    for (int w = 0; w < WORDS; w++) begin
      m10[w] = 32'(w + 1);
      m20[w] = 32'h20000000 + 32'(w);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.start_addr = '0;
    bus.write_lock_res = 1'b0; bus.write_ready = 1'b0;
    restore_mem();
    #1;
    check("rst_busy",  bus.busy, 0);
    check("rst_done",  bus.done, 0);
    check("rst_req",   bus.write_lock_req, 0);
    check("rst_valid", bus.write_data_valid, 0);
    check("rst_data",  bus.write_data, 0);
    check("rst_raddr", bus.bmem_read_addr, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // basic dump
    do_start(32'h10);
    run_frame(0);
    check("basic_timeout", timed_out, 0);
    check_frame("basic", 32'h10);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_latency", first_valid, 2);
    check("basic_raddr_capture", rd0, 32'h10);
    check("basic_raddr_after", rd1, 0);
    check("basic_busy_at_done", busy_at_done, 0);
    check("basic_stable", stab_err, 0);
    idle_check("basic_idle_after");

    // lock delay: grant only after 20 cycles of request
    bus.write_lock_res = 1'b0;
    do_start(32'h10);
    run_frame(5);
    check("lockdly_timeout", timed_out, 0);
    check_frame("lockdly", 32'h10);
    check("lockdly_wait", wait_bad, 0);
    check("lockdly_first", first_valid, 22);

    // backpressure pattern 1,0,0,1
    do_start(32'h10);
    run_frame(1);
    check("bp_timeout", timed_out, 0);
    check_frame("bp", 32'h10);
    check("bp_stable", stab_err, 0);
    check("bp_done_cnt", done_cnt, 1);

    // lock revoked for 5 cycles after byte 30
    do_start(32'h10);
    run_frame(2);
    check("revoke_timeout", timed_out, 0);
    check_frame("revoke", 32'h10);
    check("revoke_low", revoke_low, 5);
    check("revoke_stable", stab_err, 0);

    // start while busy + memory write after capture
    do_start(32'h10);
    run_frame(3);
    check("snap_timeout", timed_out, 0);
    check_frame("snap", 32'h10);
    idle_check("snap_second_start_ignored");
    restore_mem();

    // async reset at byte 40, then a fresh frame
    do_start(32'h10);
    run_frame(4);
    check("rst40_abort_at", n, 40);
    idle_check("rst40_idle");
    do_start(32'h10);
    run_frame(0);
    check("fresh_timeout", timed_out, 0);
    check_frame("fresh", 32'h10);
    check("fresh_done_cnt", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
